// File: rtl/fir_decim_q10_pkg.sv
// Q10 fixed-point helpers shared by the FM demod chain, plus the FIR
// decimator state encoding.
package functs;

  typedef logic signed [31:0] q10_t;

  localparam int Q10_BITS = 10;
  localparam int Q10_ONE  = 1024;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } fir_state_t;

  // Full-precision Q10 product: sign-extended 64-bit multiply, then an
  // arithmetic shift so fractional bits are floored (toward -inf).
  function automatic logic signed [63:0] q10mul_full(input q10_t a, input q10_t b);
    logic signed [63:0] wa;
    logic signed [63:0] wb;
    wa = 64'(a);
    wb = 64'(b);
    return (wa * wb) >>> Q10_BITS;
  endfunction

  // Q10 product truncated back to a 32-bit sample.
  function automatic q10_t q10mul(input q10_t a, input q10_t b);
    return q10_t'(q10mul_full(a, b));
  endfunction

endpackage

// File: rtl/fir_decim_q10_hist.sv
// TAPS-deep sample history ring. New samples land at wr_ptr; the read
// port returns x[n-k], i.e. the entry k places behind the newest sample.
module fir_hist_ring
  import functs::*;
#(
  parameter int TAPS   = 32,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic        [AW-1:0]     rd_k,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] hist [TAPS];
  logic        [AW-1:0]     wr_ptr;
  logic        [AW-1:0]     rd_idx;

  // Store accepted samples and advance the pointer; TAPS is a power of two so it wraps naturally.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
      end
    end else if (wr_en) begin
      hist[wr_ptr] <= wr_data;
      wr_ptr       <= wr_ptr + AW'(1);
    end
  end

  assign rd_idx  = wr_ptr - AW'(1) - rd_k;
  assign rd_data = hist[rd_idx];

endmodule

// File: rtl/fir_decim_q10.sv
// Streaming decimating Q10 FIR: collects DECIM samples, then runs one
// serial MAC pass over TAPS coefficients and presents a single output
// on a valid/ready port.
// Optional feature macro: FIR_SAT_EN (wide accumulator with saturation
// on pass completion); undefined gives a DATA_W wrapping accumulator.
module fir_decim_q10
  import functs::*;
#(
  parameter int TAPS   = 32,
  parameter int DECIM  = 8,
  parameter int DATA_W = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [DATA_W-1:0]         coef_data,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int AW = $clog2(TAPS);
  localparam int CW = $clog2(TAPS + 1);
`ifdef FIR_SAT_EN
  localparam int ACC_W = DATA_W + 8;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;
`else
  localparam int ACC_W = DATA_W;
`endif

  fir_state_t state;
  fir_state_t state_next;

  logic        [CW-1:0]     decim_cnt;
  logic        [AW-1:0]     mac_k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  prod;
  logic signed [DATA_W-1:0] coef [TAPS];
  logic signed [DATA_W-1:0] hist_rd;
  logic        [DATA_W-1:0] result;
  logic                     in_fire;
  logic                     last_sample;
  logic                     last_tap;

  assign in_fire     = in_valid && (state == S_FILL);
  assign last_sample = (decim_cnt == CW'(DECIM - 1));
  assign last_tap    = (mac_k == AW'(TAPS - 1));

  fir_hist_ring #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W)
  ) u_hist (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (in_fire),
    .wr_data (in_data),
    .rd_k    (mac_k),
    .rd_data (hist_rd)
  );

`ifdef FIR_SAT_EN
  assign prod = ACC_W'(q10mul_full(coef[mac_k], hist_rd));
`else
  assign prod = q10mul(coef[mac_k], hist_rd);
`endif

  assign acc_sum = acc + prod;

  // Final pass value: clamp the wide accumulator when saturation is built in, else plain wrap.
  always_comb begin
    result = acc_sum[DATA_W-1:0];
`ifdef FIR_SAT_EN
    if (acc_sum > SAT_MAX) begin
      result = SAT_MAX[DATA_W-1:0];
    end else if (acc_sum < SAT_MIN) begin
      result = SAT_MIN[DATA_W-1:0];
    end
`endif
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; input is only accepted while filling so no sample is lost under backpressure.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && last_sample) begin
          state_next = S_MAC;
        end
      end
      S_MAC: begin
        if (last_tap) begin
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_next = S_FILL;
        end
      end
      default: state_next = S_FILL;
    endcase
  end

  // Datapath: decimation count, coefficient writes, serial MAC and output register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      decim_cnt <= '0;
      mac_k     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        coef[i] <= '0;
      end
    end else begin
      case (state)
        S_FILL: begin
          mac_k <= '0;
          if (coef_wr_en) begin
            coef[coef_addr] <= coef_data;
          end
          if (in_fire) begin
            decim_cnt <= last_sample ? '0 : decim_cnt + CW'(1);
          end
        end
        S_MAC: begin
          acc   <= acc_sum;
          mac_k <= mac_k + AW'(1);
          if (last_tap) begin
            out_data  <= result;
            out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_decim_q10.sv
// Directed self-checking bench for fir_decim_q10 with default parameters.
module tb_fir_decim_q10;

  logic        clock;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        coef_wr_en;
  logic [4:0]  coef_addr;
  logic [31:0] coef_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] outq[$];

  fir_decim_q10 dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .coef_wr_en (coef_wr_en),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every output handshake, sampled mid-cycle before the edge that completes it.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) outq.push_back(out_data);
  end

  task automatic do_reset();
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    coef_wr_en = 1'b0;
    coef_addr  = '0;
    coef_data  = '0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    outq.delete();
  endtask

  task automatic load_coef(input int k, input logic [31:0] v);
    coef_wr_en = 1'b1;
    coef_addr  = 5'(k);
    coef_data  = v;
    @(posedge clock);
    #1;
    coef_wr_en = 1'b0;
  endtask

  task automatic send_sample(input logic [31:0] v, output bit ok);
    int n;
    n        = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    ok = (n < 200);
    if (ok) begin
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int cnt, output bit ok);
    int n;
    n = 0;
    while (outq.size() < cnt && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    ok = (outq.size() >= cnt);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (out_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_out_data: got %h expected 00000000", out_data); end
  endtask

  task automatic test_impulse();
    logic [31:0] exp_v [5] = '{32'd8192, 32'd16384, 32'd24576, 32'd32768, 32'd0};
    bit ok, all_ok;
    do_reset();
    for (int k = 0; k < 32; k++) load_coef(k, 32'((k + 1) * 1024));
    all_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_sample((i == 0) ? 32'd1024 : 32'd0, ok);
      all_ok &= ok;
    end
    wait_outputs(5, ok);
    all_ok &= ok;
    tests_run++;
    if (!all_ok) begin tests_failed++; $display("[TB] FAIL impulse_timeout: got %0d outputs expected 5", outq.size()); end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (i >= outq.size() || outq[i] !== exp_v[i]) begin
        tests_failed++;
        $display("[TB] FAIL impulse[%0d]: got %h expected %h", i, (i < outq.size()) ? outq[i] : 32'hx, exp_v[i]);
      end
    end
  endtask

  task automatic test_dc();
    logic [31:0] exp_v [5] = '{32'd256, 32'd512, 32'd768, 32'd1024, 32'd1024};
    bit ok, all_ok;
    do_reset();
    for (int k = 0; k < 32; k++) load_coef(k, 32'd32);
    all_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_sample(32'd1024, ok);
      all_ok &= ok;
    end
    wait_outputs(5, ok);
    all_ok &= ok;
    tests_run++;
    if (!all_ok) begin tests_failed++; $display("[TB] FAIL dc_timeout: got %0d outputs expected 5", outq.size()); end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (i >= outq.size() || outq[i] !== exp_v[i]) begin
        tests_failed++;
        $display("[TB] FAIL dc[%0d]: got %h expected %h", i, (i < outq.size()) ? outq[i] : 32'hx, exp_v[i]);
      end
    end
  endtask

  task automatic test_floor();
    bit ok, all_ok;
    do_reset();
    all_ok = 1'b1;
    // Coef write and first sample land on the same fill cycle; both must take effect.
    coef_wr_en = 1'b1;
    coef_addr  = 5'd0;
    coef_data  = 32'd1;
    send_sample(32'hFFFF_FFFF, ok);
    coef_wr_en = 1'b0;
    all_ok &= ok;
    for (int i = 1; i < 8; i++) begin
      send_sample(32'hFFFF_FFFF, ok);
      all_ok &= ok;
    end
    wait_outputs(1, ok);
    all_ok &= ok;
    tests_run++;
    if (!all_ok) begin tests_failed++; $display("[TB] FAIL floor_timeout: got %0d outputs expected 1", outq.size()); end
    tests_run++;
    if (outq.size() < 1 || outq[0] !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("[TB] FAIL floor: got %h expected ffffffff", (outq.size() > 0) ? outq[0] : 32'hx);
    end
  endtask

  task automatic test_overflow();
    bit ok, all_ok;
    logic [31:0] exp_v;
`ifdef FIR_SAT_EN
    exp_v = 32'h7FFF_FFFF;
`else
    exp_v = 32'hFFFF_F800;
`endif
    do_reset();
    load_coef(0, 32'd2048);
    all_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_sample(32'h7FFF_FC00, ok);
      all_ok &= ok;
    end
    wait_outputs(1, ok);
    all_ok &= ok;
    tests_run++;
    if (!all_ok) begin tests_failed++; $display("[TB] FAIL overflow_timeout: got %0d outputs expected 1", outq.size()); end
    tests_run++;
    if (outq.size() < 1 || outq[0] !== exp_v) begin
      tests_failed++;
      $display("[TB] FAIL overflow: got %h expected %h", (outq.size() > 0) ? outq[0] : 32'hx, exp_v);
    end
  endtask

  task automatic test_latency();
    bit ok, all_ok;
    int lat;
    do_reset();
    load_coef(0, 32'd1024);
    all_ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_sample(32'd5, ok);
      all_ok &= ok;
    end
    tests_run++;
    if (!all_ok || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL latency_setup: got in_ready %b expected 1", in_ready); end
    in_data  = 32'd5;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = 1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL latency_mac_in_ready: got %b expected 0", in_ready); end
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    tests_run++;
    if (lat != 33) begin tests_failed++; $display("[TB] FAIL latency: got %0d cycles expected 33", lat); end
    tests_run++;
    if (out_data !== 32'd5) begin tests_failed++; $display("[TB] FAIL latency_data: got %h expected 00000005", out_data); end
    wait_outputs(1, ok);
  endtask

  task automatic test_backpressure();
    bit ok, all_ok, valid_bad, data_bad, ready_bad;
    logic [31:0] held;
    int n;
    do_reset();
    load_coef(0, 32'd1024);
    load_coef(1, 32'd2048);
    out_ready = 1'b0;
    all_ok = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send_sample(32'(i), ok);
      all_ok &= ok;
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    tests_run++;
    if (!all_ok || out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_timeout: got out_valid %b expected 1", out_valid); end
    held = out_data;
    valid_bad = 1'b0;
    data_bad  = 1'b0;
    ready_bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1;
      if (out_valid !== 1'b1) valid_bad = 1'b1;
      if (out_data !== held)  data_bad  = 1'b1;
      if (in_ready !== 1'b0)  ready_bad = 1'b1;
    end
    tests_run++;
    if (valid_bad) begin tests_failed++; $display("[TB] FAIL bp_valid_held: got dropped expected held high"); end
    tests_run++;
    if (data_bad) begin tests_failed++; $display("[TB] FAIL bp_data_stable: got %h expected %h", out_data, held); end
    tests_run++;
    if (ready_bad) begin tests_failed++; $display("[TB] FAIL bp_in_ready: got 1 expected 0 while stalled"); end
    tests_run++;
    if (held !== 32'd22) begin tests_failed++; $display("[TB] FAIL bp_value: got %h expected 00000016", held); end
    in_data   = 32'd9;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_release_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_release_in_ready: got %b expected 1", in_ready); end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    for (int i = 10; i <= 16; i++) begin
      send_sample(32'(i), ok);
      all_ok &= ok;
    end
    wait_outputs(2, ok);
    tests_run++;
    if (!ok || outq[0] !== 32'd22 || outq[1] !== 32'd46) begin
      tests_failed++;
      $display("[TB] FAIL bp_sequence: got %0d outputs (%h, %h) expected 00000016, 0000002e", outq.size(),
               (outq.size() > 0) ? outq[0] : 32'hx, (outq.size() > 1) ? outq[1] : 32'hx);
    end
  endtask

  task automatic test_reset_mid_mac();
    bit ok, all_ok;
    do_reset();
    load_coef(0, 32'd1024);
    all_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_sample(32'd100, ok);
      all_ok &= ok;
    end
    repeat (5) @(posedge clock);
    #1;
    tests_run++;
    if (!all_ok || in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL midmac_in_mac: got in_ready %b expected 0", in_ready); end
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midmac_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midmac_in_ready: got %b expected 1", in_ready); end
    outq.delete();
    for (int i = 0; i < 8; i++) begin
      send_sample(32'd7, ok);
      all_ok &= ok;
    end
    wait_outputs(1, ok);
    repeat (40) @(posedge clock);
    #1;
    tests_run++;
    if (!ok || outq.size() != 1 || outq[0] !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL midmac_next_output: got %0d outputs first %h expected 1 output 00000000", outq.size(),
               (outq.size() > 0) ? outq[0] : 32'hx);
    end
  endtask

  task automatic test_coef_ignored();
    bit ok, all_ok;
    do_reset();
    load_coef(0, 32'd1024);
    all_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_sample(32'd3, ok);
      all_ok &= ok;
    end
    load_coef(0, 32'd4096);
    wait_outputs(1, ok);
    all_ok &= ok;
    for (int i = 0; i < 8; i++) begin
      send_sample(32'd3, ok);
      all_ok &= ok;
    end
    wait_outputs(2, ok);
    all_ok &= ok;
    tests_run++;
    if (!all_ok) begin tests_failed++; $display("[TB] FAIL coef_timeout: got %0d outputs expected 2", outq.size()); end
    tests_run++;
    if (outq.size() < 1 || outq[0] !== 32'd3) begin
      tests_failed++;
      $display("[TB] FAIL coef_pass1: got %h expected 00000003", (outq.size() > 0) ? outq[0] : 32'hx);
    end
    tests_run++;
    if (outq.size() < 2 || outq[1] !== 32'd3) begin
      tests_failed++;
      $display("[TB] FAIL coef_dropped: got %h expected 00000003", (outq.size() > 1) ? outq[1] : 32'hx);
    end
  endtask

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    coef_wr_en = 1'b0;
    coef_addr  = '0;
    coef_data  = '0;
    out_ready  = 1'b1;
    test_reset();
    test_impulse();
    test_dc();
    test_floor();
    test_overflow();
    test_latency();
    test_backpressure();
    test_reset_mid_mac();
    test_coef_ignored();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
